// File: rtl/ibex_imem_arbiter.sv
// ibex_imem_arbiter: shares one memory port between fetch and LSU with an in-order ID FIFO; define IBEX_IMEM_ARB_RR_EN for round-robin arbitration
module ibex_imem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        resp_unexp_o
);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [MaxOutstanding-1:0] ids_q;
  logic lock_q, sel_q, sel, arb_sel, held_req, full, empty, push, pop, head, unexp_q;
  assign full = count_q == CW'(MaxOutstanding);
  assign empty = count_q == '0;
`ifdef IBEX_IMEM_ARB_RR_EN
  logic rr_q;
  assign arb_sel = data_req_i & (!instr_req_i | !rr_q);
  // round-robin preference flips away from whichever port was just granted
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rr_q <= 1'b0;
    else if (push) rr_q <= sel;
  end
`else
  assign arb_sel = data_req_i;
`endif
  assign held_req = sel_q ? data_req_i : instr_req_i;
  assign sel = (lock_q & held_req) ? sel_q : arb_sel;
  assign mem_req_o = rst_ni & !full & (sel ? data_req_i : instr_req_i);
  assign mem_we_o = sel & data_we_i;
  assign mem_be_o = sel ? data_be_i : 4'hF;
  assign mem_addr_o = sel ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = sel ? data_wdata_i : '0;
  assign push = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = push & !sel;
  assign data_gnt_o = push & sel;
  assign pop = rst_ni & mem_rvalid_i & !empty;
  assign head = ids_q[rptr_q];
  assign instr_rvalid_o = pop & !head;
  assign data_rvalid_o = pop & head;
  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o = mem_rdata_i;
  assign instr_err_o = mem_err_i;
  assign data_err_o = mem_err_i;
  assign resp_unexp_o = unexp_q;
  // ID FIFO, request lock and unexpected-response flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ids_q <= '0;
      lock_q <= 1'b0;
      sel_q <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) begin
        ids_q[wptr_q] <= sel;
        wptr_q <= (wptr_q == PW'(MaxOutstanding - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) rptr_q <= (rptr_q == PW'(MaxOutstanding - 1)) ? '0 : rptr_q + PW'(1);
      lock_q <= mem_req_o & !mem_gnt_i;
      sel_q <= sel;
      if (mem_rvalid_i & empty) unexp_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ibex_imem_arbiter.sv
// tb_ibex_imem_arbiter: scoreboard bench for the shared instruction/data memory arbiter
module tb_ibex_imem_arbiter;
  logic clk_i = 1'b0, rst_ni;
  logic instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0] data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i, resp_unexp_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  int tests = 0, fails = 0;
  typedef struct packed {logic id; logic [31:0] rdata; logic err;} rsp_t;
  logic gnt_q[$];
  rsp_t rsp_q[$];
`ifdef IBEX_IMEM_ARB_RR_EN
  logic [2:0] sim_exp = 3'b101;
`else
  logic [2:0] sim_exp = 3'b111;
`endif
  always #5 clk_i = ~clk_i;
  ibex_imem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .resp_unexp_o(resp_unexp_o)
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic chk_gnt(input logic id);
    if (gnt_q.size() == 0) chk("gnt_unexpected", {31'b0, id}, 32'hffffffff);
    else chk("gnt_port", {31'b0, id}, {31'b0, gnt_q.pop_front()});
  endtask
  task automatic chk_rsp(input logic id, input logic [31:0] d, input logic e);
    rsp_t r;
    if (rsp_q.size() == 0) chk("rvalid_unexpected", {31'b0, id}, 32'hffffffff);
    else begin
      r = rsp_q.pop_front();
      chk("rsp_port", {31'b0, id}, {31'b0, r.id});
      chk("rsp_rdata", d, r.rdata);
      chk("rsp_err", {31'b0, e}, {31'b0, r.err});
    end
  endtask
  // monitor: every grant and response the DUT presents is matched against the scoreboard
  always @(negedge clk_i) begin
    if (instr_gnt_o) chk_gnt(1'b0);
    if (data_gnt_o) chk_gnt(1'b1);
    if (instr_rvalid_o) chk_rsp(1'b0, instr_rdata_o, instr_err_o);
    if (data_rvalid_o) chk_rsp(1'b1, data_rdata_o, data_err_o);
  end
  task automatic idle();
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
  endtask
  task automatic neg();
    @(negedge clk_i);
  endtask
  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask
  task automatic exp_rsp(input logic id, input logic [31:0] d, input logic e);
    rsp_t r;
    r.id = id; r.rdata = d; r.err = e;
    rsp_q.push_back(r);
  endtask
  task automatic drain(input logic id, input logic [31:0] d);
    idle(); mem_rvalid_i = 1; mem_rdata_i = d; exp_rsp(id, d, 0);
    neg(); nxt(); idle();
  endtask
  task automatic drained(input string n);
    chk({n, "_gnt_left"}, gnt_q.size(), 0);
    chk({n, "_rsp_left"}, rsp_q.size(), 0);
  endtask
  task automatic do_reset();
    idle(); rst_ni = 0; instr_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    neg();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_instr_gnt", instr_gnt_o, 0);
    nxt(); idle(); rst_ni = 1;
    neg();
    chk("rst_unexp", resp_unexp_o, 0);
    nxt();
  endtask
  initial begin
    idle(); rst_ni = 0;
    nxt();
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h100; data_be_i = 4'h3; data_wdata_i = 32'hdead; data_we_i = 1;
    mem_gnt_i = 1; gnt_q.push_back(0);
    neg();
    chk("ord_addr_i", mem_addr_o, 32'h100);
    chk("ord_be_i", mem_be_o, 4'hf);
    chk("ord_we_i", mem_we_o, 0);
    chk("ord_wdata_i", mem_wdata_o, 0);
    nxt();
    idle(); data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h2000; data_wdata_i = 32'h1234;
    mem_gnt_i = 1; gnt_q.push_back(1);
    neg();
    chk("ord_addr_d", mem_addr_o, 32'h2000);
    chk("ord_we_d", mem_we_o, 1);
    chk("ord_be_d", mem_be_o, 4'h3);
    chk("ord_wdata_d", mem_wdata_o, 32'h1234);
    nxt();
    idle(); mem_rvalid_i = 1; mem_rdata_i = 32'haaaa; exp_rsp(0, 32'haaaa, 0);
    neg(); nxt();
    idle(); mem_rvalid_i = 1; mem_rdata_i = 32'hbbbb; mem_err_i = 1; exp_rsp(1, 32'hbbbb, 1);
    neg(); nxt(); idle();
    drained("ord");
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i < 3) begin
        instr_req_i = 1; instr_addr_i = 32'h140; data_req_i = 1; data_addr_i = 32'h2400;
        mem_gnt_i = 1; gnt_q.push_back(sim_exp[i]);
      end
      if (i > 0) begin
        mem_rvalid_i = 1; mem_rdata_i = 32'h11 * i; exp_rsp(sim_exp[i-1], 32'h11 * i, 0);
      end
      neg(); nxt();
    end
    idle();
    drained("sim");
    do_reset();
    data_req_i = 1; data_addr_i = 32'h3000;
    neg();
    chk("lk_req", mem_req_o, 1);
    chk("lk_addr0", mem_addr_o, 32'h3000);
    nxt();
    for (int i = 0; i < 2; i++) begin
      idle(); data_req_i = 1; data_addr_i = 32'h3000; instr_req_i = 1; instr_addr_i = 32'h400;
      neg(); chk("lk_hold", mem_addr_o, 32'h3000); nxt();
    end
    idle(); data_req_i = 1; data_addr_i = 32'h3000; instr_req_i = 1; instr_addr_i = 32'h400;
    mem_gnt_i = 1; gnt_q.push_back(1);
    neg(); nxt();
    idle(); instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 1; gnt_q.push_back(0);
    neg(); chk("lk_next_instr", mem_addr_o, 32'h400); nxt();
    drain(1, 32'h5001); drain(0, 32'h5002);
    drained("lk");
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h500;
    neg(); nxt();
    idle(); instr_req_i = 1; instr_addr_i = 32'h500; data_req_i = 1; data_addr_i = 32'h6000;
    neg(); chk("lki_hold", mem_addr_o, 32'h500); nxt();
    idle(); instr_req_i = 1; instr_addr_i = 32'h500; data_req_i = 1; data_addr_i = 32'h6000;
    mem_gnt_i = 1; gnt_q.push_back(0);
    neg(); nxt();
    idle(); data_req_i = 1; data_addr_i = 32'h6000; mem_gnt_i = 1; gnt_q.push_back(1);
    neg(); chk("lki_data", mem_addr_o, 32'h6000); nxt();
    drain(0, 32'h6001); drain(1, 32'h6002);
    drained("lki");
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h500;
    neg(); nxt();
    idle(); data_req_i = 1; data_addr_i = 32'h6000;
    neg();
    chk("lkd_addr", mem_addr_o, 32'h6000);
    chk("lkd_req", mem_req_o, 1);
    nxt();
    idle(); data_req_i = 1; data_addr_i = 32'h6000; mem_gnt_i = 1; gnt_q.push_back(1);
    neg(); nxt();
    drain(1, 32'h6003);
    drained("lkd");
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle(); instr_req_i = 1; instr_addr_i = 32'h700; mem_gnt_i = 1; gnt_q.push_back(0);
      neg(); nxt();
    end
    idle(); instr_req_i = 1; instr_addr_i = 32'h700; mem_gnt_i = 1;
    neg(); chk("full_req0", mem_req_o, 0); nxt();
    idle(); instr_req_i = 1; instr_addr_i = 32'h700; mem_gnt_i = 1;
    mem_rvalid_i = 1; mem_rdata_i = 32'h77; exp_rsp(0, 32'h77, 0);
    neg(); chk("full_req_rv", mem_req_o, 0); nxt();
    idle(); instr_req_i = 1; instr_addr_i = 32'h700; mem_gnt_i = 1; gnt_q.push_back(0);
    neg(); chk("full_req1", mem_req_o, 1); nxt();
    drain(0, 32'h78); drain(0, 32'h79);
    drained("full");
    idle();
    neg(); chk("un0", resp_unexp_o, 0); nxt();
    mem_rvalid_i = 1; mem_rdata_i = 32'hdead;
    neg(); nxt();
    idle();
    neg(); chk("un1", resp_unexp_o, 1); nxt();
    neg(); chk("un2", resp_unexp_o, 1); nxt();
    do_reset();
    drained("end");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
